// File: rtl/ex_mem_stage.sv
// Execute stage plus EX/MEM pipeline register of the RSA-decryption ASIP, with
// operand forwarding from MEM/WB and load-use hazard detection.
// Latency: add 1 cycle; multiply N+2 edges, or N/2+2 edges when MUL_RADIX4_EN is defined.
// Backpressure: stall (combinational) freezes PC, IF/ID and ID/EX while a load-use
// hazard is resolved or the iterative multiplier is busy.
// Ports:
//   clock, reset                    posedge clock, synchronous active-high reset
//   rda_ex, rdb_ex, extended_ex     operands and immediate from ID/EX
//   ra_ex, rb_ex, rw_ex             source and destination register indices
//   wr_en_ex, opb_selector_ex, alu_func_ex, wd_selector_ex, wm_ex   controls
//   wr_en_wb, rw_wb, wd_wb          WB-stage write port, used for forwarding
//   stall                           upstream freeze
//   alu_result_mem, wdata_mem, rw_mem, wr_en_mem, wd_selector_mem, wm_mem   EX/MEM register
// Optional build macro: MUL_RADIX4_EN retires 2 multiplier bits per cycle.

module ex_mem_stage #(
  parameter int N = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] rda_ex,
  input  logic [N-1:0] rdb_ex,
  input  logic [N-1:0] extended_ex,
  input  logic [4:0]   ra_ex,
  input  logic [4:0]   rb_ex,
  input  logic [4:0]   rw_ex,
  input  logic         wr_en_ex,
  input  logic         opb_selector_ex,
  input  logic         alu_func_ex,
  input  logic         wd_selector_ex,
  input  logic         wm_ex,
  input  logic         wr_en_wb,
  input  logic [4:0]   rw_wb,
  input  logic [N-1:0] wd_wb,
  output logic         stall,
  output logic [N-1:0] alu_result_mem,
  output logic [N-1:0] wdata_mem,
  output logic [4:0]   rw_mem,
  output logic         wr_en_mem,
  output logic         wd_selector_mem,
  output logic         wm_mem
);

`ifdef MUL_RADIX4_EN
  localparam int STEPS = N / 2;
`else
  localparam int STEPS = N;
`endif
  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   mul_a;
  logic [N-1:0]   mul_b;
  logic [N-1:0]   acc;
  logic [N-1:0]   mul_wdata;
  logic [4:0]     mul_rw;
  logic           mul_wr_en;
  logic           mul_wd_sel;
  logic           mul_wm;

  logic [N-1:0]   fwd_a;
  logic [N-1:0]   fwd_b;
  logic [N-1:0]   opb;
  logic [N-1:0]   sum;
  logic           load_use;
  logic           mem_fwd_ok;
  logic [N-1:0]   addend;
  logic [N-1:0]   mul_a_nxt;
  logic [N-1:0]   mul_b_nxt;

  // A load in MEM has no data yet, so only ALU results are forwarded from MEM.
  assign mem_fwd_ok = wr_en_mem & ~wd_selector_mem & (rw_mem != 5'd0);

  always_comb begin
    fwd_a = rda_ex;
    if (mem_fwd_ok && rw_mem == ra_ex)
      fwd_a = alu_result_mem;
    else if (wr_en_wb && rw_wb == ra_ex && ra_ex != 5'd0)
      fwd_a = wd_wb;

    fwd_b = rdb_ex;
    if (mem_fwd_ok && rw_mem == rb_ex)
      fwd_b = alu_result_mem;
    else if (wr_en_wb && rw_wb == rb_ex && rb_ex != 5'd0)
      fwd_b = wd_wb;
  end

  assign opb = opb_selector_ex ? extended_ex : fwd_b;
  assign sum = fwd_a + opb;

  // B only matters when it feeds the ALU or is the store data.
  assign load_use = wr_en_mem & wd_selector_mem & (rw_mem != 5'd0) &
                    ((rw_mem == ra_ex) |
                     ((rw_mem == rb_ex) & (~opb_selector_ex | wm_ex)));

  assign stall = ((state == IDLE) & (load_use | alu_func_ex)) | (state == MUL);

  // One shift-add step; mul_b is consumed from the LSB end.
  always_comb begin
    addend    = '0;
`ifdef MUL_RADIX4_EN
    case (mul_b[1:0])
      2'd0:    addend = '0;
      2'd1:    addend = mul_a;
      2'd2:    addend = mul_a << 1;
      default: addend = (mul_a << 1) + mul_a;
    endcase
    mul_a_nxt = mul_a << 2;
    mul_b_nxt = mul_b >> 2;
`else
    addend    = mul_b[0] ? mul_a : '0;
    mul_a_nxt = mul_a << 1;
    mul_b_nxt = mul_b >> 1;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      mul_a           <= '0;
      mul_b           <= '0;
      acc             <= '0;
      mul_wdata       <= '0;
      mul_rw          <= '0;
      mul_wr_en       <= 1'b0;
      mul_wd_sel      <= 1'b0;
      mul_wm          <= 1'b0;
      alu_result_mem  <= '0;
      wdata_mem       <= '0;
      rw_mem          <= '0;
      wr_en_mem       <= 1'b0;
      wd_selector_mem <= 1'b0;
      wm_mem          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_use || alu_func_ex) begin
            // Inserted bubble: nothing downstream may act on it.
            alu_result_mem  <= '0;
            wdata_mem       <= '0;
            rw_mem          <= '0;
            wr_en_mem       <= 1'b0;
            wd_selector_mem <= 1'b0;
            wm_mem          <= 1'b0;
            if (!load_use) begin
              mul_a      <= fwd_a;
              mul_b      <= opb;
              acc        <= '0;
              cnt        <= '0;
              mul_wdata  <= fwd_b;
              mul_rw     <= rw_ex;
              mul_wr_en  <= wr_en_ex;
              mul_wd_sel <= wd_selector_ex;
              mul_wm     <= wm_ex;
              state      <= MUL;
            end
          end else begin
            alu_result_mem  <= sum;
            wdata_mem       <= fwd_b;
            rw_mem          <= rw_ex;
            wr_en_mem       <= wr_en_ex;
            wd_selector_mem <= wd_selector_ex;
            wm_mem          <= wm_ex;
          end
        end
        MUL: begin
          acc   <= acc + addend;
          mul_a <= mul_a_nxt;
          mul_b <= mul_b_nxt;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(STEPS - 1))
            state <= DONE;
        end
        DONE: begin
          alu_result_mem  <= acc;
          wdata_mem       <= mul_wdata;
          rw_mem          <= mul_rw;
          wr_en_mem       <= mul_wr_en;
          wd_selector_mem <= mul_wd_sel;
          wm_mem          <= mul_wm;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
